// File: rtl/multicycle_computer_memory_fetch_unit.sv
// multicycle_computer_memory_fetch_unit: PC/IR/DR holder bridging controller strobes to a req/ack memory
module multicycle_computer_memory_fetch_unit #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             IRWrite,
  input  logic             DataRead,
  input  logic             MemWrite,
  input  logic             PCWrite,
  input  logic             AdrSrc,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] Result,
  input  logic [WIDTH-1:0] WriteData,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] INSTRUCTION,
  output logic [WIDTH-1:0] READ_DATA,
  output logic             Stall,
  output logic             mem_error
);
  typedef enum logic [1:0] {IDLE, BUSY, COMPLETE, ERROR} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;
  state_t     state;
  op_t        op;
  logic [7:0] cnt;
  logic       access;
  assign access = IRWrite | DataRead | MemWrite;
  // the launch cycle stalls combinationally so the controller never advances past an unissued access
  assign Stall = reset && (state == IDLE ? access : state != COMPLETE);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      op          <= OP_FETCH;
      cnt         <= '0;
      PC          <= RESET_PC;
      INSTRUCTION <= '0;
      READ_DATA   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_error   <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (access) begin
            op        <= MemWrite ? OP_STORE : IRWrite ? OP_FETCH : OP_LOAD;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= AdrSrc ? ALUResult : PC;
            mem_wdata <= WriteData;
            cnt       <= '0;
            state     <= BUSY;
          end else if (PCWrite) begin
            PC <= Result;
          end
        BUSY:
          if (mem_ack) begin
            if (op == OP_FETCH) INSTRUCTION <= mem_rdata;
            if (op == OP_LOAD) READ_DATA <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= COMPLETE;
          end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
            mem_error <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state     <= ERROR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        COMPLETE: begin
          if (PCWrite) PC <= Result;
          state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_computer_memory_fetch_unit.sv
// tb_multicycle_computer_memory_fetch_unit: directed scenario tasks with hand-computed expectations
module tb_multicycle_computer_memory_fetch_unit;
  logic        clock = 0;
  logic        reset = 0;
  logic        IRWrite = 0, DataRead = 0, MemWrite = 0, PCWrite = 0, AdrSrc = 0;
  logic [31:0] ALUResult = 0, Result = 0, WriteData = 0, mem_rdata = 0;
  logic        mem_ack = 0;
  logic        mem_req, mem_we, Stall, mem_error;
  logic [31:0] mem_addr, mem_wdata, PC, INSTRUCTION, READ_DATA;
  int checks = 0, errors = 0;

  multicycle_computer_memory_fetch_unit #(.WIDTH(32), .RESET_PC(32'h100), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .IRWrite(IRWrite), .DataRead(DataRead), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ALUResult(ALUResult), .Result(Result), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .READ_DATA(READ_DATA), .Stall(Stall), .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic strobes_off;
    IRWrite = 0; DataRead = 0; MemWrite = 0; PCWrite = 0; mem_ack = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    IRWrite = 1; mem_ack = 1; mem_rdata = 32'h55555555;
    tick; tick; #1;
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h100); end
    checks++; if (INSTRUCTION !== 0) begin errors++; $display("FAIL reset_ir got %h want 0", INSTRUCTION); end
    checks++; if (mem_req !== 0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
    checks++; if (Stall !== 0) begin errors++; $display("FAIL reset_stall got %b want 0", Stall); end
    checks++; if (mem_error !== 0) begin errors++; $display("FAIL reset_err got %b want 0", mem_error); end
    strobes_off;
    reset = 1;
    tick;
  endtask

  task automatic test_fetch;
    int stalls = 0;
    IRWrite = 1; PCWrite = 1; AdrSrc = 0; Result = 32'h104; #1;
    if (Stall) stalls++;
    tick;
    checks++; if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h100) begin errors++;
      $display("FAIL fetch_launch req=%b we=%b addr=%h want 1 0 00000100", mem_req, mem_we, mem_addr); end
    checks++; if (PC !== 32'h100) begin errors++; $display("FAIL fetch_pc_held got %h want 00000100", PC); end
    if (Stall) stalls++;
    tick; if (Stall) stalls++;
    tick; if (Stall) stalls++;
    mem_ack = 1; mem_rdata = 32'hE3A01005;
    tick;
    mem_ack = 0; #1;
    checks++; if (stalls !== 4) begin errors++; $display("FAIL fetch_stall_cycles got %0d want 4", stalls); end
    checks++; if (INSTRUCTION !== 32'hE3A01005) begin errors++; $display("FAIL fetch_ir got %h want e3a01005", INSTRUCTION); end
    checks++; if (Stall !== 0 || mem_req !== 0 || PC !== 32'h100) begin errors++;
      $display("FAIL fetch_complete stall=%b req=%b pc=%h want 0 0 00000100", Stall, mem_req, PC); end
    tick;
    strobes_off; #1;
    checks++; if (PC !== 32'h104) begin errors++; $display("FAIL fetch_pc_commit got %h want 00000104", PC); end
    checks++; if (mem_req !== 0 || Stall !== 0) begin errors++; $display("FAIL fetch_no_relaunch req=%b stall=%b want 0 0", mem_req, Stall); end
  endtask

  task automatic test_load;
    DataRead = 1; AdrSrc = 1; ALUResult = 32'h2000;
    tick;
    checks++; if (mem_addr !== 32'h2000 || mem_we !== 0 || mem_req !== 1) begin errors++;
      $display("FAIL load_launch addr=%h we=%b req=%b want 00002000 0 1", mem_addr, mem_we, mem_req); end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    tick;
    strobes_off;
    checks++; if (READ_DATA !== 32'hDEADBEEF) begin errors++; $display("FAIL load_dr got %h want deadbeef", READ_DATA); end
    checks++; if (INSTRUCTION !== 32'hE3A01005) begin errors++; $display("FAIL load_ir_hold got %h want e3a01005", INSTRUCTION); end
    tick;
  endtask

  task automatic test_store;
    MemWrite = 1; IRWrite = 1; AdrSrc = 1; ALUResult = 32'h2004; WriteData = 32'h12345678;
    tick;
    WriteData = 32'h0BADF00D; ALUResult = 32'h3000;
    checks++; if (mem_we !== 1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h2004) begin errors++;
      $display("FAIL store_launch we=%b wdata=%h addr=%h want 1 12345678 00002004", mem_we, mem_wdata, mem_addr); end
    tick;
    checks++; if (mem_we !== 1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h2004) begin errors++;
      $display("FAIL store_hold we=%b wdata=%h addr=%h want 1 12345678 00002004", mem_we, mem_wdata, mem_addr); end
    mem_ack = 1; mem_rdata = 32'hAAAA5555;
    tick;
    strobes_off;
    checks++; if (mem_req !== 0 || mem_we !== 0) begin errors++; $display("FAIL store_drop req=%b we=%b want 0 0", mem_req, mem_we); end
    checks++; if (READ_DATA !== 32'hDEADBEEF || INSTRUCTION !== 32'hE3A01005) begin errors++;
      $display("FAIL store_no_capture dr=%h ir=%h want deadbeef e3a01005", READ_DATA, INSTRUCTION); end
    tick;
  endtask

  task automatic test_timeout;
    IRWrite = 1; AdrSrc = 0;
    tick;
    for (int i = 0; i < 14; i++) tick;
    checks++; if (mem_error !== 0 || mem_req !== 1) begin errors++;
      $display("FAIL timeout_early err=%b req=%b want 0 1", mem_error, mem_req); end
    tick;
    checks++; if (mem_error !== 1 || mem_req !== 0 || Stall !== 1) begin errors++;
      $display("FAIL timeout_err err=%b req=%b stall=%b want 1 0 1", mem_error, mem_req, Stall); end
    mem_ack = 1; mem_rdata = 32'h11111111;
    tick;
    mem_ack = 0;
    checks++; if (INSTRUCTION !== 32'hE3A01005 || mem_error !== 1 || mem_req !== 0 || Stall !== 1) begin errors++;
      $display("FAIL timeout_late_ack ir=%h err=%b req=%b stall=%b want e3a01005 1 0 1", INSTRUCTION, mem_error, mem_req, Stall); end
    strobes_off;
    reset = 0;
    tick;
    checks++; if (mem_error !== 0 || PC !== 32'h100 || Stall !== 0) begin errors++;
      $display("FAIL timeout_reset err=%b pc=%h stall=%b want 0 00000100 0", mem_error, PC, Stall); end
    reset = 1;
    tick;
  endtask

  task automatic test_reset_mid_busy;
    IRWrite = 1; AdrSrc = 0;
    tick;
    reset = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D; PCWrite = 1; Result = 32'h500;
    tick;
    checks++; if (INSTRUCTION !== 0 || PC !== 32'h100 || mem_req !== 0 || Stall !== 0) begin errors++;
      $display("FAIL abort ir=%h pc=%h req=%b stall=%b want 0 00000100 0 0", INSTRUCTION, PC, mem_req, Stall); end
    reset = 1; strobes_off;
    tick;
    PCWrite = 1; Result = 32'hFFFFFFFF; #1;
    checks++; if (Stall !== 0) begin errors++; $display("FAIL pcwrite_stall got %b want 0", Stall); end
    tick;
    checks++; if (PC !== 32'hFFFFFFFF) begin errors++; $display("FAIL pcwrite_pc got %h want ffffffff", PC); end
    Result = 32'h0; mem_ack = 1; mem_rdata = 32'h77777777;
    tick;
    strobes_off;
    checks++; if (PC !== 0 || INSTRUCTION !== 0 || mem_req !== 0) begin errors++;
      $display("FAIL pc_wrap pc=%h ir=%h req=%b want 0 0 0", PC, INSTRUCTION, mem_req); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_store;
    test_timeout;
    test_reset_mid_busy;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
